sifreleme_denetleyici: RTL and testbench

Sequencing and arbitration controller for the shared bit-manipulation/crypto unit `sifreleme_birimi`. It accepts operations from two requesters over valid/ready handshakes and grants the unit round-robin. It registers operands, runs one operation through the combinational unit, and returns a registered result to the owning requester. It sits between the execute stage (requester 0) and the auxiliary/coprocessor port (requester 1) and the single `sifreleme_birimi` instance.

---
 rtl/sifreleme_denetleyici_pkg.sv | 64 ++++++
 rtl/sifreleme_birimi.sv | 38 +++
 rtl/sifreleme_denetleyici.sv | 144 ++++++++++++++
 tb/tb_sifreleme_denetleyici.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sifreleme_denetleyici_pkg.sv
// -----------------------------------------------------------------------------
// sifreleme_denetleyici_pkg
//   Shared constants for the crypto/bit-manipulation controller and its
//   combinational unit: op-code encodings, controller state encodings,
//   op-code width, and small helper functions used by sifreleme_birimi.
//   No ports (package).
// -----------------------------------------------------------------------------
package sifreleme_denetleyici_pkg;

    // Datapath width; 32 is the only supported value.
    localparam int SIFRELEME_VERI_BIT     = 32;
    localparam int SIFRELEME_KONTROL_BIT  = 3;

    // Op-code encodings. 3'd6 and 3'd7 are undefined and report an error.
    localparam logic [SIFRELEME_KONTROL_BIT-1:0] SIFRELEME_HMDST = 3'd0; // Hamming distance
    localparam logic [SIFRELEME_KONTROL_BIT-1:0] SIFRELEME_PKG   = 3'd1; // pack low halves
    localparam logic [SIFRELEME_KONTROL_BIT-1:0] SIFRELEME_RVRS  = 3'd2; // bit reverse
    localparam logic [SIFRELEME_KONTROL_BIT-1:0] SIFRELEME_SLADD = 3'd3; // (a << 1) + b
    localparam logic [SIFRELEME_KONTROL_BIT-1:0] SIFRELEME_CNTZ  = 3'd4; // trailing zeros
    localparam logic [SIFRELEME_KONTROL_BIT-1:0] SIFRELEME_CNTP  = 3'd5; // population count

    // Controller state encodings.
    localparam logic [1:0] SD_BOSTA   = 2'd0;
    localparam logic [1:0] SD_HESAPLA = 2'd1;
    localparam logic [1:0] SD_YANIT   = 2'd2;

    // True when the op code is one of the six defined operations.
    function automatic logic kontrol_gecerli(input logic [SIFRELEME_KONTROL_BIT-1:0] kontrol);
        return kontrol inside {SIFRELEME_HMDST, SIFRELEME_PKG, SIFRELEME_RVRS,
                               SIFRELEME_SLADD, SIFRELEME_CNTZ, SIFRELEME_CNTP};
    endfunction

    // Number of set bits.
    function automatic logic [5:0] bit_say(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    // Number of zero bits below the lowest set bit; 32 for an all-zero word.
    function automatic logic [5:0] sondaki_sifir(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd32;
        // Scanning downward leaves n at the lowest set index.
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) n = 6'(i);
        end
        return n;
    endfunction

    // Bit order reversal.
    function automatic logic [31:0] ters_cevir(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sifreleme_birimi.sv
// -----------------------------------------------------------------------------
// sifreleme_birimi
//   Purely combinational bit-manipulation/crypto unit.
//   Ports:
//     kontrol_i  in  3        op code (SIFRELEME_* encodings)
//     deger1_i   in  VERI_BIT operand 1
//     deger2_i   in  VERI_BIT operand 2
//     sonuc_o    out VERI_BIT result; zero for undefined op codes
// -----------------------------------------------------------------------------
module sifreleme_birimi
    import sifreleme_denetleyici_pkg::*;
#(
    parameter int VERI_BIT = SIFRELEME_VERI_BIT
) (
    input  logic [SIFRELEME_KONTROL_BIT-1:0] kontrol_i,
    input  logic [VERI_BIT-1:0]              deger1_i,
    input  logic [VERI_BIT-1:0]              deger2_i,
    output logic [VERI_BIT-1:0]              sonuc_o
);

    localparam int YARIM = VERI_BIT / 2;

    always_comb begin
        // NOTE: every output of an always_comb gets a default before the case,
        // so an unlisted op code can never leave it holding an old value (latch).
        sonuc_o = '0;
        case (kontrol_i)
            SIFRELEME_HMDST: sonuc_o = {{(VERI_BIT-6){1'b0}}, bit_say(deger1_i ^ deger2_i)};
            SIFRELEME_PKG:   sonuc_o = {deger2_i[YARIM-1:0], deger1_i[YARIM-1:0]};
            SIFRELEME_RVRS:  sonuc_o = ters_cevir(deger1_i);
            SIFRELEME_SLADD: sonuc_o = (deger1_i << 1) + deger2_i;
            SIFRELEME_CNTZ:  sonuc_o = {{(VERI_BIT-6){1'b0}}, sondaki_sifir(deger1_i)};
            SIFRELEME_CNTP:  sonuc_o = {{(VERI_BIT-6){1'b0}}, bit_say(deger1_i)};
            default:         sonuc_o = '0;
        endcase
    end

endmodule

// File: rtl/sifreleme_denetleyici.sv
// -----------------------------------------------------------------------------
// sifreleme_denetleyici
//   Round-robin arbiter and sequencer in front of one sifreleme_birimi.
//   Accepts one operation at a time from two requesters, computes it in one
//   cycle from registered operands, and returns a registered result to the
//   requester that issued it. Three states: BOSTA -> HESAPLA -> YANIT.
//   Ports:
//     clk_i            in  1    clock, rising edge
//     rst_ni           in  1    synchronous active-low reset
//     istek_gecerli_i  in  2    request valid per requester
//     istek_hazir_o    out 2    request accepted this cycle (one-hot or zero)
//     istek_kontrol_i  in  6    op code, 3 bits per requester
//     istek_deger1_i   in  64   operand 1, VERI_BIT per requester
//     istek_deger2_i   in  64   operand 2, VERI_BIT per requester
//     yanit_gecerli_o  out 2    response valid to the owner (one-hot or zero)
//     yanit_hazir_i    in  2    requester ready to take its response
//     yanit_sonuc_o    out 32   registered result
//     yanit_hata_o     out 1    op code was undefined
//     mesgul_o         out 1    controller not idle
// -----------------------------------------------------------------------------
module sifreleme_denetleyici
    import sifreleme_denetleyici_pkg::*;
#(
    parameter int VERI_BIT = SIFRELEME_VERI_BIT
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [1:0]                         istek_gecerli_i,
    output logic [1:0]                         istek_hazir_o,
    input  logic [2*SIFRELEME_KONTROL_BIT-1:0] istek_kontrol_i,
    input  logic [2*VERI_BIT-1:0]              istek_deger1_i,
    input  logic [2*VERI_BIT-1:0]              istek_deger2_i,
    output logic [1:0]                         yanit_gecerli_o,
    input  logic [1:0]                         yanit_hazir_i,
    output logic [VERI_BIT-1:0]                yanit_sonuc_o,
    output logic                               yanit_hata_o,
    output logic                               mesgul_o
);

    localparam int KB = SIFRELEME_KONTROL_BIT;

    logic [1:0]          r_durum;
    logic                r_son_kazanan;
    logic                r_sahip;
    logic [KB-1:0]       r_kontrol;
    logic [VERI_BIT-1:0] r_deger1;
    logic [VERI_BIT-1:0] r_deger2;
    logic [VERI_BIT-1:0] r_sonuc;
    logic                r_hata;

    logic                w_kazanan;
    logic                w_kabul;
    logic                w_yanit_aktif;
    logic                w_yanit_alindi;
    logic [KB-1:0]       w_sec_kontrol;
    logic [VERI_BIT-1:0] w_sec_deger1;
    logic [VERI_BIT-1:0] w_sec_deger2;
    logic [VERI_BIT-1:0] w_birim_sonuc;

    // Arbitration: on a tie the requester that did not win last time goes.
    always_comb begin
        w_kazanan = 1'b0;
        if (istek_gecerli_i == 2'b11) begin
            w_kazanan = ~r_son_kazanan;
        end else if (istek_gecerli_i[1]) begin
            w_kazanan = 1'b1;
        end
    end

    // Acceptance is suppressed while reset is asserted so no handshake is
    // reported for a request the registers are not going to capture.
    assign w_kabul = rst_ni && (r_durum == SD_BOSTA) && (|istek_gecerli_i);

    assign istek_hazir_o = {w_kabul & w_kazanan, w_kabul & ~w_kazanan};

    assign w_sec_kontrol = w_kazanan ? istek_kontrol_i[2*KB-1:KB]
                                     : istek_kontrol_i[KB-1:0];
    assign w_sec_deger1  = w_kazanan ? istek_deger1_i[2*VERI_BIT-1:VERI_BIT]
                                     : istek_deger1_i[VERI_BIT-1:0];
    assign w_sec_deger2  = w_kazanan ? istek_deger2_i[2*VERI_BIT-1:VERI_BIT]
                                     : istek_deger2_i[VERI_BIT-1:0];

    assign w_yanit_aktif  = (r_durum == SD_YANIT);
    // Only the owner's ready can complete the response.
    assign w_yanit_alindi = w_yanit_aktif && yanit_hazir_i[r_sahip];

    assign yanit_gecerli_o = {w_yanit_aktif & r_sahip, w_yanit_aktif & ~r_sahip};
    assign yanit_sonuc_o   = r_sonuc;
    assign yanit_hata_o    = r_hata;
    assign mesgul_o        = (r_durum != SD_BOSTA);

    sifreleme_birimi #(
        .VERI_BIT (VERI_BIT)
    ) u_birim (
        .kontrol_i (r_kontrol),
        .deger1_i  (r_deger1),
        .deger2_i  (r_deger2),
        .sonuc_o   (w_birim_sonuc)
    );

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_ni) begin
            r_durum       <= SD_BOSTA;
            r_son_kazanan <= 1'b1;
            r_sahip       <= 1'b0;
            r_sonuc       <= '0;
            r_hata        <= 1'b0;
        end else begin
            case (r_durum)
                SD_BOSTA: begin
                    if (w_kabul) begin
                        r_sahip <= w_kazanan;
                        r_durum <= SD_HESAPLA;
                    end
                end
                SD_HESAPLA: begin
                    r_hata  <= ~kontrol_gecerli(r_kontrol);
                    r_sonuc <= kontrol_gecerli(r_kontrol) ? w_birim_sonuc : '0;
                    r_durum <= SD_YANIT;
                end
                SD_YANIT: begin
                    if (w_yanit_alindi) begin
                        r_son_kazanan <= r_sahip;
                        r_durum       <= SD_BOSTA;
                    end
                end
                default: r_durum <= SD_BOSTA;
            endcase
        end
    end

    // NOTE: operand registers carry no reset; they are always loaded at
    // acceptance before the unit output is used, so a reset value is never seen.
    always_ff @(posedge clk_i) begin
        if (w_kabul) begin
            r_kontrol <= w_sec_kontrol;
            r_deger1  <= w_sec_deger1;
            r_deger2  <= w_sec_deger2;
        end
    end

endmodule

// File: tb/tb_sifreleme_denetleyici.sv
// -----------------------------------------------------------------------------
// tb_sifreleme_denetleyici
//   Directed self-checking bench for sifreleme_denetleyici. Inputs change just
//   after the falling edge; outputs are sampled 1 time unit later, well away
//   from the rising edge where state updates.
// -----------------------------------------------------------------------------
module tb_sifreleme_denetleyici;
    import sifreleme_denetleyici_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  istek_gecerli_i;
    logic [1:0]  istek_hazir_o;
    logic [5:0]  istek_kontrol_i;
    logic [63:0] istek_deger1_i;
    logic [63:0] istek_deger2_i;
    logic [1:0]  yanit_gecerli_o;
    logic [1:0]  yanit_hazir_i;
    logic [31:0] yanit_sonuc_o;
    logic        yanit_hata_o;
    logic        mesgul_o;

    int n_kontrol = 0;
    int n_hata    = 0;

    always #5 clk_i = ~clk_i;

    sifreleme_denetleyici #(
        .VERI_BIT (32)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .istek_gecerli_i (istek_gecerli_i),
        .istek_hazir_o   (istek_hazir_o),
        .istek_kontrol_i (istek_kontrol_i),
        .istek_deger1_i  (istek_deger1_i),
        .istek_deger2_i  (istek_deger2_i),
        .yanit_gecerli_o (yanit_gecerli_o),
        .yanit_hazir_i   (yanit_hazir_i),
        .yanit_sonuc_o   (yanit_sonuc_o),
        .yanit_hata_o    (yanit_hata_o),
        .mesgul_o        (mesgul_o)
    );

    task automatic check(input string etiket, input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
        n_kontrol++;
        if (gozlenen !== beklenen) begin
            n_hata++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     etiket, gozlenen, beklenen, $time);
        end
    endtask

    task automatic sonraki();
        @(negedge clk_i);
    endtask

    task automatic istek_ayarla(input int k, input logic [2:0] kontrol,
                                input logic [31:0] d1, input logic [31:0] d2);
        istek_kontrol_i[3*k +: 3] = kontrol;
        istek_deger1_i[32*k +: 32] = d1;
        istek_deger2_i[32*k +: 32] = d2;
    endtask

    task automatic adim_kontrol(input string etiket, input logic [1:0] hazir,
                                input logic [1:0] gecerli, input logic mesgul);
        check({etiket, ".hazir"},   32'(istek_hazir_o),   32'(hazir));
        check({etiket, ".gecerli"}, 32'(yanit_gecerli_o), 32'(gecerli));
        check({etiket, ".mesgul"},  32'(mesgul_o),        32'(mesgul));
    endtask

    task automatic yanit_kontrol(input string etiket, input logic [1:0] gecerli,
                                 input logic [31:0] sonuc, input logic hata);
        check({etiket, ".gecerli"}, 32'(yanit_gecerli_o), 32'(gecerli));
        check({etiket, ".sonuc"},   yanit_sonuc_o,        sonuc);
        check({etiket, ".hata"},    32'(yanit_hata_o),    32'(hata));
    endtask

    task automatic reset_uygula();
        rst_ni          = 1'b0;
        istek_gecerli_i = 2'b00;
        sonraki();
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [2:0] tanimsiz;
        rst_ni          = 1'b0;
        istek_gecerli_i = 2'b00;
        istek_kontrol_i = '0;
        istek_deger1_i  = '0;
        istek_deger2_i  = '0;
        yanit_hazir_i   = 2'b11;

        // Reset state.
        reset_uygula();
        #1;
        adim_kontrol("reset", 2'b00, 2'b00, 1'b0);
        yanit_kontrol("reset", 2'b00, 32'h0, 1'b0);

        // Single HMDST from requester 0.
        istek_ayarla(0, SIFRELEME_HMDST, 32'hf0f0_f0f0, 32'hfff0_f0f0);
        istek_gecerli_i = 2'b01;
        #1;
        check("t1.hazir_N", 32'(istek_hazir_o), 32'h1);
        sonraki(); istek_gecerli_i = 2'b00; #1;
        adim_kontrol("t1.N1", 2'b00, 2'b00, 1'b1);
        sonraki(); #1;
        yanit_kontrol("t1.N2", 2'b01, 32'd4, 1'b0);
        sonraki(); #1;
        adim_kontrol("t1.N3", 2'b00, 2'b00, 1'b0);

        // Simultaneous requests after reset: requester 0 wins the first tie.
        reset_uygula();
        istek_ayarla(0, SIFRELEME_PKG,   32'hffff_000f, 32'hffff_0f0f);
        istek_ayarla(1, SIFRELEME_SLADD, 32'd16,        32'd38);
        istek_gecerli_i = 2'b11;
        #1;
        check("t2.tie1", 32'(istek_hazir_o), 32'h1);
        // Requester 0 issues a new op immediately; requester 1 keeps waiting.
        sonraki(); istek_ayarla(0, SIFRELEME_RVRS, 32'h0000_0001, 32'h0); #1;
        adim_kontrol("t2.hes0", 2'b00, 2'b00, 1'b1);
        sonraki(); #1;
        yanit_kontrol("t2.yan0", 2'b01, 32'h0f0f_000f, 1'b0);
        check("t2.yan0.hazir", 32'(istek_hazir_o), 32'h0);
        sonraki(); #1;
        check("t2.tie2", 32'(istek_hazir_o), 32'h2);
        sonraki(); istek_gecerli_i = 2'b01; #1;
        adim_kontrol("t2.hes1", 2'b00, 2'b00, 1'b1);
        sonraki(); #1;
        yanit_kontrol("t2.yan1", 2'b10, 32'd70, 1'b0);
        sonraki(); #1;
        check("t2.kalan0", 32'(istek_hazir_o), 32'h1);
        sonraki(); istek_gecerli_i = 2'b00; #1;
        sonraki(); #1;
        yanit_kontrol("t2.yan2", 2'b01, 32'h8000_0000, 1'b0);
        sonraki(); #1;
        adim_kontrol("t2.bos", 2'b00, 2'b00, 1'b0);

        // Backpressure on requester 1; non-owner ready must be ignored.
        yanit_hazir_i = 2'b01;
        istek_ayarla(1, SIFRELEME_RVRS, 32'hffff_0000, 32'h0);
        istek_gecerli_i = 2'b10;
        #1;
        check("t3.kabul", 32'(istek_hazir_o), 32'h2);
        sonraki();
        istek_ayarla(0, SIFRELEME_CNTP, 32'h0000_00ff, 32'h0);
        istek_gecerli_i = 2'b01;
        #1;
        adim_kontrol("t3.hes", 2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            sonraki(); #1;
            adim_kontrol("t3.bekle", 2'b00, 2'b10, 1'b1);
            yanit_kontrol("t3.bekle", 2'b10, 32'h0000_ffff, 1'b0);
        end
        sonraki(); yanit_hazir_i = 2'b10; #1;
        yanit_kontrol("t3.teslim", 2'b10, 32'h0000_ffff, 1'b0);
        sonraki(); yanit_hazir_i = 2'b11; #1;
        check("t3.sonra0", 32'(istek_hazir_o), 32'h1);
        sonraki(); istek_gecerli_i = 2'b00; #1;
        sonraki(); #1;
        yanit_kontrol("t3.yan0", 2'b01, 32'd8, 1'b0);
        sonraki(); #1;
        adim_kontrol("t3.bos", 2'b00, 2'b00, 1'b0);

        // Undefined op codes from requester 1.
        for (int i = 0; i < 2; i++) begin
            tanimsiz = (i == 0) ? 3'd6 : 3'd7;
            istek_ayarla(1, tanimsiz, 32'hffff_ffff, 32'hffff_ffff);
            istek_gecerli_i = 2'b10;
            #1;
            check("t5.kabul", 32'(istek_hazir_o), 32'h2);
            sonraki(); istek_gecerli_i = 2'b00; #1;
            adim_kontrol("t5.hes", 2'b00, 2'b00, 1'b1);
            sonraki(); #1;
            yanit_kontrol("t5.yan", 2'b10, 32'h0, 1'b1);
            sonraki(); #1;
            adim_kontrol("t5.bos", 2'b00, 2'b00, 1'b0);
        end

        // Back-to-back on requester 0: acceptances exactly 3 cycles apart.
        istek_ayarla(0, SIFRELEME_CNTZ, 32'hffff_0000, 32'h0);
        istek_gecerli_i = 2'b01;
        #1;
        check("t4.kabulT", 32'(istek_hazir_o), 32'h1);
        sonraki(); istek_ayarla(0, SIFRELEME_CNTP, 32'hf000_0000, 32'h0); #1;
        adim_kontrol("t4.T1", 2'b00, 2'b00, 1'b1);
        sonraki(); #1;
        yanit_kontrol("t4.T2", 2'b01, 32'd16, 1'b0);
        check("t4.T2.hazir", 32'(istek_hazir_o), 32'h0);
        sonraki(); #1;
        check("t4.kabulT3", 32'(istek_hazir_o), 32'h1);
        sonraki(); istek_gecerli_i = 2'b00; #1;
        sonraki(); #1;
        yanit_kontrol("t4.T5", 2'b01, 32'd4, 1'b0);
        sonraki(); #1;
        adim_kontrol("t4.bos", 2'b00, 2'b00, 1'b0);

        // Reset while in HESAPLA: operation is dropped, no response ever.
        istek_ayarla(0, SIFRELEME_HMDST, 32'hf0f0_f0f0, 32'hfff0_f0f0);
        istek_gecerli_i = 2'b01;
        #1;
        check("t6.kabul", 32'(istek_hazir_o), 32'h1);
        sonraki(); istek_gecerli_i = 2'b00; rst_ni = 1'b0; #1;
        adim_kontrol("t6.hes", 2'b00, 2'b00, 1'b1);
        sonraki(); rst_ni = 1'b1; #1;
        adim_kontrol("t6.sonra", 2'b00, 2'b00, 1'b0);
        yanit_kontrol("t6.sonra", 2'b00, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            sonraki(); #1;
            adim_kontrol("t6.sessiz", 2'b00, 2'b00, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_kontrol, n_hata);
        $finish;
    end

    // Safety net: the directed sequence is far shorter than this.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of sequence");
        $fatal(1, "watchdog expired");
    end

endmodule
